// File: rtl/branch_ctrl_pkg.sv
// Shared encodings for the EX-stage branch controller: branch types, FSM states
// and the conditional-branch classifier used by the statistics logic.
package branch_ctrl_pkg;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_NONE = 3'b010,
        BR_JUMP = 3'b011,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_type_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_e;

    // Conditional branches are beq, bne and the whole 1xx group.
    function automatic logic is_cond_branch(input logic [2:0] br_type);
        return (br_type == BR_BEQ) || (br_type == BR_BNE) || br_type[2];
    endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// EX-stage branch bus between the pipeline and branch_ctrl.
// The master is the pipeline (plus the branch-condition unit); the slave is the controller.
interface branch_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) ();
    logic             ex_valid;
    logic [2:0]       ex_br_type;
    logic [XLEN-1:0]  ex_target;
    logic             stall;
    logic [2:0]       bc_type;
    logic             bc_taken;
    logic             pc_sel;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush;
    logic             misalign_exc;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output ex_valid, ex_br_type, ex_target, stall, bc_taken,
        input  bc_type, pc_sel, redirect_pc, flush, misalign_exc, br_cnt, taken_cnt
    );

    modport slave (
        input  ex_valid, ex_br_type, ex_target, stall, bc_taken,
        output bc_type, pc_sel, redirect_pc, flush, misalign_exc, br_cnt, taken_cnt
    );
endinterface

// File: rtl/branch_ctrl_stat_counter.sv
// Free-running event counter with enable; wraps modulo 2^CNT_W.
module br_stat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (en)
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch sequencer: gates the branch-condition unit, latches taken targets,
// drives the fetch redirect/flush and counts resolved branches.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   ST_IDLE     | EX content is on the correct path; branches may resolve
//   ST_REDIRECT | fetch redirected to redirect_pc, EX content is wrong path
module branch_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input logic          clk,
    input logic          rst,
    branch_ctrl_if.slave bus
);
    import branch_ctrl_pkg::*;

    state_e          state_q;
    state_e          state_d;
    logic            resolve;
    logic            target_ok;
    logic            redir_go;
    logic            misal_go;
    logic [XLEN-1:0] redirect_q;
    logic            misal_q;

    assign resolve   = (state_q == ST_IDLE) && bus.ex_valid && !bus.stall &&
                       (bus.ex_br_type != BR_NONE);
    assign target_ok = (bus.ex_target[1:0] == 2'b00);
    assign redir_go  = resolve && bus.bc_taken && target_ok;
    assign misal_go  = resolve && bus.bc_taken && !target_ok;

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (redir_go) state_d = ST_REDIRECT;
            ST_REDIRECT: if (!bus.stall) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.pc_sel  = (state_q == ST_REDIRECT);
        bus.flush   = (state_q == ST_REDIRECT);
        bus.bc_type = (bus.ex_valid && state_q == ST_IDLE) ? bus.ex_br_type : BR_NONE;
    end

    // Target only loads on a fresh redirect, so it stays stable across stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_q <= '0;
            misal_q    <= 1'b0;
        end else begin
            if (redir_go)
                redirect_q <= bus.ex_target;
            misal_q <= misal_go;
        end
    end

    assign bus.redirect_pc  = redirect_q;
    assign bus.misalign_exc = misal_q;

    br_stat_counter #(.CNT_W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (resolve && is_cond_branch(bus.ex_br_type)),
        .count (bus.br_cnt)
    );

    br_stat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (resolve && bus.bc_taken),
        .count (bus.taken_cnt)
    );

endmodule
